// File: rtl/t0_feeder.sv
// -----------------------------------------------------------------------------
// t0_feeder
//   Byte FIFO between the host link and the core. The host side is a
//   valid/ready stream. The core side is a four-phase request/acknowledge
//   handshake: one byte per request-high/request-low cycle.
//
// Ports
//   clk          system clock; all state updates on the rising edge
//   N_reset      asynchronous active-low reset
//   in_valid     upstream byte valid
//   in_data      upstream byte
//   in_ready     FIFO can accept a byte this cycle (not full)
//   data_request core request for the next byte (level signal)
//   data_ready   data holds the byte for the current request
//   data         byte presented to the core
//   level        FIFO occupancy, 0..DEPTH
//   underrun     sticky: the core waited on an empty FIFO
//   underrun_clr synchronous clear of underrun
// -----------------------------------------------------------------------------
module t0_feeder #(
  parameter int DEPTH = 16  // power of two, 2..256
) (
  input  logic                     clk,
  input  logic                     N_reset,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  input  logic                     data_request,
  output logic                     data_ready,
  output logic [7:0]               data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun,
  input  logic                     underrun_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    state;
  logic [1:0]    next_state;
  logic          push;
  logic          pop;

  // Full is judged from the registered count only, so the host side never
  // sees a path from data_request.
  assign in_ready = (level != LW'(DEPTH));
  assign push     = in_valid & in_ready;

  // A pop only happens when leaving IDLE/WAIT towards ACK. Because the byte is
  // read from storage that already held it before this edge, a byte pushed
  // on this same edge can never be the one popped.
  assign pop = ((state == IDLE) || (state == WAIT)) && data_request && (level != '0);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (data_request) next_state = (level != '0) ? ACK : WAIT;
      end
      WAIT: begin
        if (!data_request)      next_state = IDLE;
        else if (level != '0)   next_state = ACK;
      end
      ACK: begin
        if (!data_request) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: storage has no reset. Its contents are meaningless until written,
  // and leaving it out of the reset keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      data       <= 8'h00;
      data_ready <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= next_state;
      data_ready <= (next_state == ACK);

      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        data   <= mem[rd_ptr];
      end

      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      // Setting takes priority over the clear in the same cycle.
      if (state == WAIT)     underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_t0_feeder.sv
// -----------------------------------------------------------------------------
// tb_t0_feeder
//   Self-checking bench for t0_feeder. The reference model is a byte queue
//   plus two flags describing the core handshake ("holding a byte",
//   "waiting on empty"). Every byte the model hands out is pushed onto a
//   scoreboard queue. A separate monitor pops that queue each time
//   data_ready rises and compares it with data.
// -----------------------------------------------------------------------------
module tb_t0_feeder;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          N_reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          data_request;
  logic          data_ready;
  logic [7:0]    data;
  logic [LW-1:0] level;
  logic          underrun;
  logic          underrun_clr;

  t0_feeder #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .N_reset      (N_reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .data_request (data_request),
    .data_ready   (data_ready),
    .data         (data),
    .level        (level),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #20 clk = ~clk;  // 25 MHz

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  byte unsigned m_q[$];     // bytes stored in the FIFO, oldest first
  byte unsigned exp_q[$];   // bytes the core should see, in order
  bit           m_holding;  // core currently holds a presented byte
  bit           m_waiting;  // core is requesting on an empty FIFO
  bit           m_under;

  logic         mon_prev_dr;
  logic [7:0]   mon_last_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of behaviour, from the pre-edge view of the model.
  task automatic model_step(input bit v, input byte unsigned d, input bit req, input bit clr);
    int sz       = m_q.size();
    bit was_wait = m_waiting;
    if (!m_holding && req && sz > 0) begin
      exp_q.push_back(m_q.pop_front());
      m_holding = 1'b1;
      m_waiting = 1'b0;
    end else if (!req) begin
      m_holding = 1'b0;
      m_waiting = 1'b0;
    end else if (!m_holding) begin
      m_waiting = 1'b1;
    end
    if (v && sz != DEPTH) m_q.push_back(d);
    if (was_wait) m_under = 1'b1;
    else if (clr) m_under = 1'b0;
  endtask

  task automatic check_outputs();
    check("level",      32'(level),      32'(m_q.size()));
    check("in_ready",   32'(in_ready),   32'(m_q.size() != DEPTH));
    check("data_ready", 32'(data_ready), 32'(m_holding));
    check("underrun",   32'(underrun),   32'(m_under));
  endtask

  task automatic cycle(input bit v, input byte unsigned d, input bit req, input bit clr);
    in_valid     = v;
    in_data      = d;
    data_request = req;
    underrun_clr = clr;
    @(posedge clk);
    model_step(v, d, req, clr);
    #1;
    check_outputs();
  endtask

  // Four-phase drain of whatever the model still holds, with a cycle budget.
  task automatic drain(input string name);
    int guard = 0;
    while ((m_q.size() > 0 || m_holding) && guard < 8 * DEPTH + 20) begin
      cycle(1'b0, 8'h00, !m_holding, 1'b0);
      guard++;
    end
    check({name, "_drained"}, 32'(m_q.size()), 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted part-way through a cycle and held across an
  // edge with push and request both active.
  task automatic reset_mid();
    #3 N_reset = 1'b0;
    #1;
    check("rst_data_ready", 32'(data_ready), 32'd0);
    check("rst_level",      32'(level),      32'd0);
    check("rst_underrun",   32'(underrun),   32'd0);
    check("rst_data",       32'(data),       32'h00);
    check("rst_in_ready",   32'(in_ready),   32'd1);
    in_valid     = 1'b1;
    in_data      = 8'h5A;
    data_request = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hold_level", 32'(level),      32'd0);
    check("rst_hold_dr",    32'(data_ready), 32'd0);
    m_q.delete();
    exp_q.delete();
    m_holding = 1'b0;
    m_waiting = 1'b0;
    m_under   = 1'b0;
    @(negedge clk);
    N_reset      = 1'b1;
    in_valid     = 1'b0;
    data_request = 1'b0;
  endtask

  // Monitor: compares presented bytes against the scoreboard and checks that
  // data never changes except when a new byte is presented.
  initial begin
    mon_prev_dr   = 1'b0;
    mon_last_data = 8'h00;
    forever begin
      @(negedge clk);
      if (N_reset) begin
        if (data_ready && !mon_prev_dr) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pop_byte: got %0h, expected no byte (t=%0t)", data, $time);
          end else begin
            check("pop_byte", 32'(data), 32'(exp_q.pop_front()));
          end
        end else begin
          check("data_hold", 32'(data), 32'(mon_last_data));
        end
      end
      mon_prev_dr   = data_ready;
      mon_last_data = data;
    end
  end

  initial begin
    N_reset      = 1'b0;
    in_valid     = 1'b0;
    in_data      = 8'h00;
    data_request = 1'b0;
    underrun_clr = 1'b0;
    m_holding    = 1'b0;
    m_waiting    = 1'b0;
    m_under      = 1'b0;
    #1;
    check("init_level",      32'(level),      32'd0);
    check("init_in_ready",   32'(in_ready),   32'd1);
    check("init_data_ready", 32'(data_ready), 32'd0);
    check("init_data",       32'(data),       32'h00);
    check("init_underrun",   32'(underrun),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    N_reset = 1'b1;

    // Three bytes, then three separate four-phase reads.
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end

    // Request on an empty FIFO, then the byte arrives.
    repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'hA5, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Overfill: the last two bytes must be dropped.
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    drain("overfill");

    // Request held high for 10 clocks with 4 bytes queued: a single pop.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    repeat (10) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    drain("hold");

    // Random traffic: continuous pushes with four-phase reads, well past
    // 3*DEPTH bytes so both pointers wrap several times.
    for (int i = 0; i < 500; i++) begin
      bit v   = ($urandom_range(0, 3) != 0);
      bit req = m_holding ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      bit clr = ($urandom_range(0, 15) == 0);
      cycle(v, 8'($urandom), req, clr);
    end
    drain("random");

    // Reset while a byte is presented, 5 bytes queued and underrun set.
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'hE0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(8'hE0 + i), 1'b1, 1'b0);
    reset_mid();

    // After reset: the first push lands on the next edge, and a request on
    // the empty FIFO waits and raises underrun.
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    drain("post_reset");
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
